// File: rtl/control_pkg.sv
// Shared definitions for the multi-cycle control FSM.
// Covers state encoding, MIPS opcode/funct constants and the decode bundle.
package control_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_t;

  localparam int CNT_W = 8;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;

  typedef struct packed {
    logic       r_format;
    logic       i_format;
    logic       lw;
    logic       sw;
    logic       jr;
    logic       jmp;
    logic       jal;
    logic       branch;
    logic       nbranch;
    logic       sftmd;
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_dec_t;

  function automatic logic is_shift_funct(input logic [5:0] f);
    case (f)
      FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Instruction-field inputs, I/O handshake and control outputs of the control FSM.
// The master side is the FSM and the slave side is the datapath.
interface control_fsm_if #(
  parameter int ADDR_HIGH_W = 22
);
  logic [5:0]             Opcode;
  logic [5:0]             Function_opcode;
  logic [ADDR_HIGH_W-1:0] Alu_resultHigh;
  logic                   io_ready;

  logic       IR_en;
  logic       PC_en;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       IORead;
  logic       IOWrite;
  logic       MemorIOtoReg;
  logic       RegDST;
  logic       ALUSrc;
  logic       Jr;
  logic       Jmp;
  logic       Jal;
  logic       Branch;
  logic       nBranch;
  logic       I_format;
  logic       Sftmd;
  logic [1:0] ALUOp;
  logic [2:0] state;
  logic       io_err;

  modport master (
    input  Opcode, Function_opcode, Alu_resultHigh, io_ready,
    output IR_en, PC_en, RegWrite, MemRead, MemWrite, IORead, IOWrite,
           MemorIOtoReg, RegDST, ALUSrc, Jr, Jmp, Jal, Branch, nBranch,
           I_format, Sftmd, ALUOp, state, io_err
  );

  modport slave (
    output Opcode, Function_opcode, Alu_resultHigh, io_ready,
    input  IR_en, PC_en, RegWrite, MemRead, MemWrite, IORead, IOWrite,
           MemorIOtoReg, RegDST, ALUSrc, Jr, Jmp, Jal, Branch, nBranch,
           I_format, Sftmd, ALUOp, state, io_err
  );
endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational instruction decode: opcode/funct to ungated decode levels.
module ctrl_decode
  import control_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_dec_t  dec
);

  logic r_fmt, i_fmt, is_lw, is_sw, is_jr, is_j, is_jal, is_beq, is_bne, is_sft;

  assign r_fmt  = (opcode == OP_RTYPE);
  assign i_fmt  = (opcode[5:3] == 3'b001);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_j   = (opcode == OP_J);
  assign is_jal = (opcode == OP_JAL);
  assign is_beq = (opcode == OP_BEQ);
  assign is_bne = (opcode == OP_BNE);
  assign is_jr  = r_fmt & (funct == FN_JR);
  assign is_sft = r_fmt & is_shift_funct(funct);

  assign dec = '{
    r_format: r_fmt,
    i_format: i_fmt,
    lw:       is_lw,
    sw:       is_sw,
    jr:       is_jr,
    jmp:      is_j,
    jal:      is_jal,
    branch:   is_beq,
    nbranch:  is_bne,
    sftmd:    is_sft,
    reg_dst:  r_fmt,
    alu_src:  i_fmt | is_lw | is_sw,
    alu_op:   {r_fmt | i_fmt, is_beq | is_bne}
  };

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with memory wait states and a
// timed-out I/O handshake; decode levels come from ctrl_decode, gated by state.
module control_fsm
  import control_pkg::*;
#(
  parameter int                     ADDR_HIGH_W = 22,
  parameter logic [ADDR_HIGH_W-1:0] IO_PAGE     = '1,
  parameter int                     MEM_WAIT    = 1,
  parameter int                     IO_TIMEOUT  = 8
) (
  input logic           clock,
  input logic           reset,
  control_fsm_if.master bus
);

  localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_WAIT);
  localparam logic [CNT_W-1:0] IO_LAST  = CNT_W'(IO_TIMEOUT - 1);

  ctrl_dec_t        dec;
  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             is_io_q, is_io_n;
  logic             io_err_q, io_err_n;
  logic             ir_en_q, pc_en_q, reg_write_q, mem_to_reg_q;
  logic             mem_read_q, mem_write_q, io_read_q, io_write_q;
  logic             to_mem, to_wb, mem_done, io_fail, dec_vld, in_mem_n;

  ctrl_decode u_decode (
    .opcode (bus.Opcode),
    .funct  (bus.Function_opcode),
    .dec    (dec)
  );

  assign to_mem   = dec.lw | dec.sw;
  assign to_wb    = (dec.r_format & ~dec.jr) | dec.i_format | dec.jal;
  assign io_fail  = is_io_q & ~bus.io_ready & (cnt_q == IO_LAST);
  assign mem_done = is_io_q ? (bus.io_ready | (cnt_q == IO_LAST)) : (cnt_q == MEM_LAST);

  always_comb begin
    state_n  = ST_IF;
    cnt_n    = cnt_q;
    is_io_n  = is_io_q;
    io_err_n = io_err_q;
    case (state_q)
      // Out of reset IR_en is still low, so IF is held one cycle to raise it.
      ST_IF: state_n = ir_en_q ? ST_ID : ST_IF;
      ST_ID: state_n = ST_EX;
      ST_EX: begin
        if (to_mem) begin
          state_n = ST_MEM;
          cnt_n   = '0;
          is_io_n = (bus.Alu_resultHigh == IO_PAGE);
        end else if (to_wb) begin
          state_n = ST_WB;
        end
      end
      ST_MEM: begin
        if (!mem_done) begin
          state_n = ST_MEM;
          if (cnt_q != '1) cnt_n = cnt_q + 1'b1;
        end else if (io_fail) begin
          io_err_n = 1'b1;
        end else if (dec.lw) begin
          state_n = ST_WB;
        end
      end
      default: state_n = ST_IF;
    endcase
  end

  assign in_mem_n = (state_n == ST_MEM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IF;
      cnt_q        <= '0;
      is_io_q      <= 1'b0;
      io_err_q     <= 1'b0;
      ir_en_q      <= 1'b0;
      pc_en_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      io_read_q    <= 1'b0;
      io_write_q   <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      is_io_q      <= is_io_n;
      io_err_q     <= io_err_n;
      ir_en_q      <= (state_n == ST_IF);
      reg_write_q  <= (state_n == ST_WB);
      mem_to_reg_q <= dec.lw & (in_mem_n | (state_n == ST_WB));
      mem_read_q   <= in_mem_n & dec.lw & ~is_io_n;
      mem_write_q  <= in_mem_n & dec.sw & ~is_io_n;
      io_read_q    <= in_mem_n & dec.lw & is_io_n;
      io_write_q   <= in_mem_n & dec.sw & is_io_n;
      // Last-cycle flag for every exit whose timing is known ahead of time.
      pc_en_q      <= (state_n == ST_WB)
                    | ((state_n == ST_EX) & ~to_mem & ~to_wb)
                    | (in_mem_n & dec.sw & ~is_io_n & (cnt_n == MEM_LAST));
    end
  end

  assign dec_vld = (state_q == ST_ID) | (state_q == ST_EX) |
                   (state_q == ST_MEM) | (state_q == ST_WB);

  // An I/O exit depends on io_ready in the same cycle, so its PC_en cannot be pre-registered.
  assign bus.PC_en = pc_en_q |
                     ((state_q == ST_MEM) & ((is_io_q & dec.sw & bus.io_ready) | io_fail));

  assign bus.IR_en        = ir_en_q;
  assign bus.RegWrite     = reg_write_q;
  assign bus.MemRead      = mem_read_q;
  assign bus.MemWrite     = mem_write_q;
  assign bus.IORead       = io_read_q;
  assign bus.IOWrite      = io_write_q;
  assign bus.MemorIOtoReg = mem_to_reg_q;
  assign bus.RegDST       = dec_vld & dec.reg_dst;
  assign bus.ALUSrc       = dec_vld & dec.alu_src;
  assign bus.Jr           = dec_vld & dec.jr;
  assign bus.Jmp          = dec_vld & dec.jmp;
  assign bus.Jal          = dec_vld & dec.jal;
  assign bus.Branch       = dec_vld & dec.branch;
  assign bus.nBranch      = dec_vld & dec.nbranch;
  assign bus.I_format     = dec_vld & dec.i_format;
  assign bus.Sftmd        = dec_vld & dec.sftmd;
  assign bus.ALUOp        = dec_vld ? dec.alu_op : 2'b00;
  assign bus.state        = state_q;
  assign bus.io_err       = io_err_q;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: each instruction pushes its expected per-cycle
// output vectors; they are popped and compared cycle by cycle on the falling edge.
module tb_control_fsm;

  localparam int              AW         = 22;
  localparam int              MEM_WAIT   = 1;
  localparam int              IO_TIMEOUT = 8;
  localparam logic [AW-1:0]   IO_ADDR    = '1;

  typedef enum int {K_ALU, K_BR, K_LW, K_SW} kind_t;
  typedef struct {
    logic        rdy;
    logic [22:0] vec;
    string       tag;
  } sb_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  control_fsm_if #(.ADDR_HIGH_W(AW)) bus ();

  control_fsm #(
    .ADDR_HIGH_W (AW),
    .IO_PAGE     (IO_ADDR),
    .MEM_WAIT    (MEM_WAIT),
    .IO_TIMEOUT  (IO_TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  sb_t         sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        err_exp = 1'b0;
  logic [22:0] obs;

  assign obs = {bus.state, bus.IR_en, bus.PC_en, bus.RegWrite, bus.MemRead, bus.MemWrite,
                bus.IORead, bus.IOWrite, bus.MemorIOtoReg, bus.RegDST, bus.ALUSrc, bus.Jr,
                bus.Jmp, bus.Jal, bus.Branch, bus.nBranch, bus.I_format, bus.Sftmd,
                bus.ALUOp, bus.io_err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected vector; decode levels (dec = {RegDST,ALUSrc,Jr,Jmp,Jal,Branch,nBranch,I_format,Sftmd}) only when dv.
  function automatic logic [22:0] mk(input int st, input logic ir, pc, rw, mr, mw, ior, iow,
                                     m2r, dv, input logic [8:0] dec, input logic [1:0] aop,
                                     input logic err);
    return {3'(st), ir, pc, rw, mr, mw, ior, iow, m2r,
            dv ? dec : 9'd0, dv ? aop : 2'd0, err};
  endfunction

  task automatic push(input string tag, input logic rdy, input logic [22:0] vec);
    sb_t e;
    e.rdy = rdy;
    e.vec = vec;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                     input logic [AW-1:0] addr, input logic [8:0] dec, input logic [1:0] aop,
                     input kind_t kind, input int ready_at, input logic noise);
    logic io, lw, ok, last, first;
    int   n;
    sb_t  e;
    io = (addr == IO_ADDR) && (kind == K_LW || kind == K_SW);
    lw = (kind == K_LW);
    ok = 1'b1;
    push({name, " IF"}, noise, mk(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, dec, aop, err_exp));
    push({name, " ID"}, noise, mk(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, dec, aop, err_exp));
    push({name, " EX"}, noise, mk(2, 1'b0, kind == K_BR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, dec, aop, err_exp));
    if (kind == K_ALU) begin
      push({name, " WB"}, noise, mk(4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, dec, aop, err_exp));
    end else if (kind != K_BR) begin
      if (!io) n = MEM_WAIT + 1;
      else if (ready_at >= 0 && ready_at < IO_TIMEOUT) n = ready_at + 1;
      else begin
        n  = IO_TIMEOUT;
        ok = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
        last = (i == n - 1);
        push($sformatf("%s MEM%0d", name, i), io ? (i == ready_at) : noise,
             mk(3, 1'b0, last && (!lw || !ok), 1'b0, lw && !io, !lw && !io, lw && io, !lw && io,
                lw, 1'b1, dec, aop, err_exp));
      end
      if (!ok) err_exp = 1'b1;
      if (lw && ok)
        push({name, " WB"}, noise, mk(4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, dec, aop, err_exp));
    end
    first = 1'b1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(posedge clock);
      #1;
      if (first) begin
        bus.Opcode          = op;
        bus.Function_opcode = fn;
        bus.Alu_resultHigh  = addr;
        first = 1'b0;
      end
      bus.io_ready = e.rdy;
      @(negedge clock);
      check(e.tag, 32'(obs), 32'(e.vec));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    bus.Opcode          = 6'h00;
    bus.Function_opcode = 6'h00;
    bus.Alu_resultHigh  = '0;
    bus.io_ready        = 1'b0;

    @(negedge clock);
    check("reset hold 1", 32'(obs), 32'd0);
    @(negedge clock);
    check("reset hold 2", 32'(obs), 32'd0);
    reset = 1'b0;

    run("add",     6'h00, 6'h20, 22'h000000, 9'h100, 2'b10, K_ALU, -1, 1'b1);
    run("lw_mem",  6'h23, 6'h00, 22'h000000, 9'h080, 2'b00, K_LW,  -1, 1'b1);
    run("sw_mem",  6'h2B, 6'h00, 22'h000123, 9'h080, 2'b00, K_SW,  -1, 1'b0);
    run("sw_io",   6'h2B, 6'h00, IO_ADDR,    9'h080, 2'b00, K_SW,   2, 1'b1);
    run("lw_io0",  6'h23, 6'h00, IO_ADDR,    9'h080, 2'b00, K_LW,   0, 1'b0);
    run("lw_io7",  6'h23, 6'h00, IO_ADDR,    9'h080, 2'b00, K_LW,   7, 1'b1);
    run("jr",      6'h00, 6'h08, 22'h000000, 9'h140, 2'b10, K_BR,  -1, 1'b0);
    run("beq",     6'h04, 6'h00, 22'h000000, 9'h008, 2'b01, K_BR,  -1, 1'b1);
    run("bne",     6'h05, 6'h00, 22'h000000, 9'h004, 2'b01, K_BR,  -1, 1'b0);
    run("j",       6'h02, 6'h00, 22'h000000, 9'h020, 2'b00, K_BR,  -1, 1'b0);
    run("undef",   6'h3F, 6'h00, 22'h000000, 9'h000, 2'b00, K_BR,  -1, 1'b0);
    run("jal",     6'h03, 6'h00, 22'h000000, 9'h010, 2'b00, K_ALU, -1, 1'b0);
    run("addi",    6'h08, 6'h00, 22'h000000, 9'h082, 2'b10, K_ALU, -1, 1'b0);
    run("sll",     6'h00, 6'h00, 22'h000000, 9'h101, 2'b10, K_ALU, -1, 1'b1);
    run("lw_tmo",  6'h23, 6'h00, IO_ADDR,    9'h080, 2'b00, K_LW,  -1, 1'b0);
    run("sw_tmo",  6'h2B, 6'h00, IO_ADDR,    9'h080, 2'b00, K_SW,  -1, 1'b0);
    run("add_err", 6'h00, 6'h20, 22'h000000, 9'h100, 2'b10, K_ALU, -1, 1'b0);

    // Reset pulse in the middle of an I/O load while io_err is set.
    @(posedge clock);
    #1;
    bus.Opcode          = 6'h23;
    bus.Function_opcode = 6'h00;
    bus.Alu_resultHigh  = IO_ADDR;
    bus.io_ready        = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (bus.state == 3'd3) found = 1'b1;
    end
    check("rst_mid reached MEM", 32'(found), 32'd1);
    check("rst_mid IORead before", 32'(bus.IORead), 32'd1);
    check("rst_mid io_err before", 32'(bus.io_err), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid immediate", 32'(obs), 32'd0);
    @(posedge clock);
    #1;
    check("rst_mid held", 32'(obs), 32'd0);
    @(negedge clock);
    reset   = 1'b0;
    err_exp = 1'b0;

    run("add_rst", 6'h00, 6'h20, 22'h000000, 9'h100, 2'b10, K_ALU, -1, 1'b0);
    run("lw_post", 6'h23, 6'h00, 22'h000042, 9'h080, 2'b00, K_LW,  -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
